instr_load_arbiter: RTL and testbench
=====================================

// Module: instr_load_arbiter
// PURPOSE
// - Shares the instruction register's single write port between two requesters (ch0, ch1).
// - Per-channel valid/ready handshake; round-robin arbitration between channels.
// - Drives the register's load_en, write_pointer, opcode and operand fields from one registered stage.
// - Allocates write slots sequentially, tracks occupancy, and stalls requesters when the register is full.
// PARAMETERS
// - OPW    32  operand width; signed, matches operand_t
// - OPCW   4   opcode width, matches opcode_t
// - DEPTH  32  number of instruction register entries
// - AW     5   address width, matches address_t; 2**AW == DEPTH
// PORTS
// - clk              in   1        single clock, all state on posedge
// - reset            in   1        asynchronous, active-high reset
// - req0_valid       in   1        ch0 has an instruction to load
// - req0_ready       out  1        ch0 accepted this cycle when valid&&ready
// - req0_opcode      in   OPCW     ch0 opcode
// - req0_operand_a   in   OPW      ch0 operand A
// - req0_operand_b   in   OPW      ch0 operand B
// - req1_valid, req1_ready, req1_opcode, req1_operand_a, req1_operand_b: same as ch0, for ch1
// - clear            in   1        synchronous flush: empties the slot allocation
// - load_en          out  1        write strobe to the instruction register
// - write_pointer    out  AW       slot being written while load_en=1
// - opcode           out  OPCW     opcode to load
// - operand_a        out  OPW      operand A to load
// - operand_b        out  OPW      operand B to load
// - grant_id         out  1        channel that owns the current load_en beat
// - count            out  AW+1     number of slots written since reset/clear, 0..DEPTH
// - full             out  1        count==DEPTH
// BEHAVIOUR
// - Reset: async, active-high, takes effect immediately.
//   - load_en=0, write_pointer=0, opcode=0, operand_a=0, operand_b=0, grant_id=0, count=0, full=0.
//   - FSM=EMPTY; last_grant=1, so ch0 wins the first tie.
//   - A load_en beat pending at reset is dropped.
// - FSM states: EMPTY (count==0), FILLING (0<count<DEPTH), FULL (count==DEPTH).
//   - EMPTY->FILLING on accept.
//   - FILLING->FULL on accept when count==DEPTH-1.
//   - FILLING/FULL->EMPTY on clear.
// - Ready (combinational from valid, state, last_grant, clear):
//   - Both ready signals are 0 when in FULL or when clear=1.
//   - Otherwise, only ch0 valid: req0_ready=1. Only ch1 valid: req1_ready=1.
//   - Both valid: grant the channel != last_grant. last_grant updates on every accept.
//   - req0_ready and req1_ready are never high in the same cycle.
// - Accept in cycle N (valid&&ready):
//   - Cycle N+1: load_en=1; opcode/operands carry the winner's fields from cycle N.
//   - write_pointer = wr_ptr value at cycle N; grant_id = winner.
//   - wr_ptr and count increment at the cycle N edge.
//   - Latency is 1 cycle. Back-to-back accepts sustain 1 load per cycle.
// - No accept in cycle N: load_en=0 in N+1; data outputs hold their last values.
// - wr_ptr wraps from DEPTH-1 to 0, reachable only after a clear. No writes occur while FULL.
// - Clear:
//   - wr_ptr=0, count=0, full=0 at the next edge; FSM->EMPTY.
//   - Clear wins over a simultaneous valid, because ready is forced to 0.
//   - A load_en beat already issued in the cycle clear is sampled still completes.
// - count saturates at DEPTH. full is registered and equals (count==DEPTH).
// - Requester fields are sampled only on accept. A requester must hold valid and its fields until ready.
// TESTING
// - Reset then ch0 valid alone with opc=ADD, a=5, b=3 -> next cycle load_en=1, write_pointer=0, opcode=ADD, operand_a=5, operand_b=3, grant_id=0, count=1.
// - ch0 and ch1 both valid for 4 cycles -> grants alternate 0,1,0,1; write_pointer 0,1,2,3; count=4; ready is never high on both channels.
// - 32 back-to-back accepts from ch1 -> full=1 after the 32nd; a 33rd valid sees req1_ready=0 and no load_en; FSM=FULL.
// - While FULL, pulse clear with ch0 valid -> ch0 ready=0 that cycle; next cycle count=0 and full=0; following accept writes write_pointer=0.
// - Assert reset mid-stream right after an accept -> load_en=0 immediately, count=0; after release, a ch0/ch1 tie grants ch0 first.

Source files
------------

// File: rtl/instr_load_arbiter_if.sv
// Request/load bundle between two instruction requesters and the instruction register write port.
// The slave modport is the arbiter; the master modport is the requester/register side.
interface instr_load_arbiter_if #(
  parameter int unsigned OPW  = 32,
  parameter int unsigned OPCW = 4,
  parameter int unsigned AW   = 5
);
  logic                   req0_valid;
  logic                   req0_ready;
  logic [OPCW-1:0]        req0_opcode;
  logic signed [OPW-1:0]  req0_operand_a;
  logic signed [OPW-1:0]  req0_operand_b;

  logic                   req1_valid;
  logic                   req1_ready;
  logic [OPCW-1:0]        req1_opcode;
  logic signed [OPW-1:0]  req1_operand_a;
  logic signed [OPW-1:0]  req1_operand_b;

  logic                   clear;

  logic                   load_en;
  logic [AW-1:0]          write_pointer;
  logic [OPCW-1:0]        opcode;
  logic signed [OPW-1:0]  operand_a;
  logic signed [OPW-1:0]  operand_b;
  logic                   grant_id;
  logic [AW:0]            count;
  logic                   full;

  modport slave (
    input  req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
    input  req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
    input  clear,
    output req0_ready, req1_ready,
    output load_en, write_pointer, opcode, operand_a, operand_b, grant_id, count, full
  );

  modport master (
    output req0_valid, req0_opcode, req0_operand_a, req0_operand_b,
    output req1_valid, req1_opcode, req1_operand_a, req1_operand_b,
    output clear,
    input  req0_ready, req1_ready,
    input  load_en, write_pointer, opcode, operand_a, operand_b, grant_id, count, full
  );
endinterface

// File: rtl/instr_load_arbiter.sv
// Round-robin arbiter sharing the instruction register write port between two channels.
// One registered output stage; sequential slot allocation with occupancy tracking and full stall.
module instr_load_arbiter #(
  parameter int unsigned OPW   = 32,
  parameter int unsigned OPCW  = 4,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_load_arbiter_if.slave   bus
);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FullCount = CW'(DEPTH);
  localparam logic [AW:0] LastCount = CW'(DEPTH - 1);

  typedef enum logic [1:0] {StEmpty, StFilling, StFull} state_t;

  state_t                r_state;
  logic                  r_last_grant;
  logic [AW-1:0]         r_wr_ptr;
  logic [AW:0]           r_count;
  logic                  r_full;
  logic                  r_load_en;
  logic [AW-1:0]         r_write_pointer;
  logic [OPCW-1:0]       r_opcode;
  logic signed [OPW-1:0] r_operand_a;
  logic signed [OPW-1:0] r_operand_b;
  logic                  r_grant_id;

  logic                  w_block;
  logic                  w_ready0;
  logic                  w_ready1;
  logic                  w_accept;
  logic                  w_winner;
  logic [OPCW-1:0]       w_sel_opcode;
  logic signed [OPW-1:0] w_sel_operand_a;
  logic signed [OPW-1:0] w_sel_operand_b;

  // On a tie the channel that did not win last is granted; the two readies are exclusive.
  always_comb begin
    w_block  = (r_state == StFull) || bus.clear;
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (!w_block) begin
      if (bus.req0_valid && bus.req1_valid) begin
        w_ready0 = r_last_grant;
        w_ready1 = !r_last_grant;
      end else begin
        w_ready0 = bus.req0_valid;
        w_ready1 = bus.req1_valid;
      end
    end
  end

  always_comb begin
    w_accept        = (bus.req0_valid && w_ready0) || (bus.req1_valid && w_ready1);
    w_winner        = bus.req1_valid && w_ready1;
    w_sel_opcode    = w_winner ? bus.req1_opcode    : bus.req0_opcode;
    w_sel_operand_a = w_winner ? bus.req1_operand_a : bus.req0_operand_a;
    w_sel_operand_b = w_winner ? bus.req1_operand_b : bus.req0_operand_b;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= StEmpty;
      r_last_grant    <= 1'b1;
      r_wr_ptr        <= '0;
      r_count         <= '0;
      r_full          <= 1'b0;
      r_load_en       <= 1'b0;
      r_write_pointer <= '0;
      r_opcode        <= '0;
      r_operand_a     <= '0;
      r_operand_b     <= '0;
      r_grant_id      <= 1'b0;
    end else begin
      r_load_en <= w_accept;
      if (w_accept) begin
        r_write_pointer <= r_wr_ptr;
        r_opcode        <= w_sel_opcode;
        r_operand_a     <= w_sel_operand_a;
        r_operand_b     <= w_sel_operand_b;
        r_grant_id      <= w_winner;
        r_last_grant    <= w_winner;
      end

      // Ready is forced low under clear, so clear and accept never coincide.
      if (bus.clear) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_full   <= 1'b0;
        r_state  <= StEmpty;
      end else if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count != FullCount) begin
          r_count <= r_count + CW'(1);
        end
        unique case (r_state)
          StEmpty, StFilling: begin
            if (r_count == LastCount) begin
              r_state <= StFull;
              r_full  <= 1'b1;
            end else begin
              r_state <= StFilling;
            end
          end
          StFull: r_state <= StFull;
          default: r_state <= StEmpty;
        endcase
      end
    end
  end

  assign bus.req0_ready    = w_ready0;
  assign bus.req1_ready    = w_ready1;
  assign bus.load_en       = r_load_en;
  assign bus.write_pointer = r_write_pointer;
  assign bus.opcode        = r_opcode;
  assign bus.operand_a     = r_operand_a;
  assign bus.operand_b     = r_operand_b;
  assign bus.grant_id      = r_grant_id;
  assign bus.count         = r_count;
  assign bus.full          = r_full;
endmodule

// File: tb/tb_instr_load_arbiter.sv
// Directed bench for instr_load_arbiter: reset, single load, tie alternation, fill to full,
// clear while full, and reset mid-stream.
module tb_instr_load_arbiter;
  localparam int unsigned OPW   = 32;
  localparam int unsigned OPCW  = 4;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned AW    = 5;

  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpC0  = 4'h2;
  localparam logic [3:0] OpC1  = 4'h3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  instr_load_arbiter_if #(.OPW(OPW), .OPCW(OPCW), .AW(AW)) bus ();

  instr_load_arbiter #(.OPW(OPW), .OPCW(OPCW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch0(input logic v, input logic [3:0] op, input logic signed [31:0] a,
                         input logic signed [31:0] b);
    bus.req0_valid     = v;
    bus.req0_opcode    = op;
    bus.req0_operand_a = a;
    bus.req0_operand_b = b;
  endtask

  task automatic set_ch1(input logic v, input logic [3:0] op, input logic signed [31:0] a,
                         input logic signed [31:0] b);
    bus.req1_valid     = v;
    bus.req1_opcode    = op;
    bus.req1_operand_a = a;
    bus.req1_operand_b = b;
  endtask

  initial begin
    logic exp_g;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.clear = 1'b0;
    set_ch0(1'b0, 4'h0, 0, 0);
    set_ch1(1'b0, 4'h0, 0, 0);
    settle();

    // Reset state
    chk("rst_load_en", 32'(bus.load_en), 32'd0);
    chk("rst_wp", 32'(bus.write_pointer), 32'd0);
    chk("rst_opcode", 32'(bus.opcode), 32'd0);
    chk("rst_opa", bus.operand_a, 32'd0);
    chk("rst_opb", bus.operand_b, 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_full", 32'(bus.full), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Single ch0 load: ADD 5,3
    set_ch0(1'b1, OpAdd, 5, 3);
    settle();
    chk("single_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("single_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    set_ch0(1'b0, 4'h0, 0, 0);
    chk("single_load_en", 32'(bus.load_en), 32'd1);
    chk("single_wp", 32'(bus.write_pointer), 32'd0);
    chk("single_opcode", 32'(bus.opcode), 32'(OpAdd));
    chk("single_opa", bus.operand_a, 32'd5);
    chk("single_opb", bus.operand_b, 32'd3);
    chk("single_grant", 32'(bus.grant_id), 32'd0);
    chk("single_count", 32'(bus.count), 32'd1);
    tick();
    chk("idle_load_en", 32'(bus.load_en), 32'd0);
    chk("idle_hold_opa", bus.operand_a, 32'd5);

    // Fresh reset so the tie starts with ch0
    reset = 1'b1;
    settle();
    reset = 1'b0;
    tick();

    set_ch0(1'b1, OpC0, -7, 100);
    set_ch1(1'b1, OpC1, 11, -1);
    for (int i = 0; i < 4; i++) begin
      exp_g = i[0];
      settle();
      chk("tie_rdy0", 32'(bus.req0_ready), 32'(!exp_g));
      chk("tie_rdy1", 32'(bus.req1_ready), 32'(exp_g));
      tick();
      chk("tie_load_en", 32'(bus.load_en), 32'd1);
      chk("tie_grant", 32'(bus.grant_id), 32'(exp_g));
      chk("tie_wp", 32'(bus.write_pointer), 32'(i));
      chk("tie_opcode", 32'(bus.opcode), exp_g ? 32'(OpC1) : 32'(OpC0));
      chk("tie_opa", bus.operand_a, exp_g ? 32'd11 : 32'hFFFF_FFF9);
      chk("tie_opb", bus.operand_b, exp_g ? 32'hFFFF_FFFF : 32'd100);
    end
    chk("tie_count", 32'(bus.count), 32'd4);
    set_ch0(1'b0, 4'h0, 0, 0);
    set_ch1(1'b0, 4'h0, 0, 0);

    // Clear, then fill from ch1
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    chk("clr_count", 32'(bus.count), 32'd0);
    for (int i = 0; i < 32; i++) begin
      set_ch1(1'b1, OpC1, i, 32 - i);
      settle();
      chk("fill_rdy1", 32'(bus.req1_ready), 32'd1);
      chk("fill_full_pre", 32'(bus.full), 32'd0);
      tick();
      chk("fill_load_en", 32'(bus.load_en), 32'd1);
      chk("fill_wp", 32'(bus.write_pointer), 32'(i));
      chk("fill_opa", bus.operand_a, 32'(i));
      chk("fill_count", 32'(bus.count), 32'(i + 1));
    end
    chk("fill_full", 32'(bus.full), 32'd1);
    set_ch1(1'b1, OpC1, 99, 99);
    settle();
    chk("full_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    chk("full_no_load", 32'(bus.load_en), 32'd0);
    chk("full_count_sat", 32'(bus.count), 32'd32);
    set_ch1(1'b0, 4'h0, 0, 0);

    // Clear while full with ch0 valid
    set_ch0(1'b1, OpAdd, 21, 22);
    bus.clear = 1'b1;
    settle();
    chk("clr_rdy0", 32'(bus.req0_ready), 32'd0);
    chk("clr_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    bus.clear = 1'b0;
    chk("clr_full_count", 32'(bus.count), 32'd0);
    chk("clr_full_flag", 32'(bus.full), 32'd0);
    chk("clr_no_load", 32'(bus.load_en), 32'd0);
    settle();
    chk("post_clr_rdy0", 32'(bus.req0_ready), 32'd1);
    tick();
    chk("post_clr_load_en", 32'(bus.load_en), 32'd1);
    chk("post_clr_wp", 32'(bus.write_pointer), 32'd0);
    chk("post_clr_opa", bus.operand_a, 32'd21);
    chk("post_clr_count", 32'(bus.count), 32'd1);

    // Reset mid-stream, right after an accept
    reset = 1'b1;
    settle();
    chk("midrst_load_en", 32'(bus.load_en), 32'd0);
    chk("midrst_count", 32'(bus.count), 32'd0);
    chk("midrst_opa", bus.operand_a, 32'd0);
    tick();
    reset = 1'b0;
    set_ch0(1'b1, OpC0, 1, 2);
    set_ch1(1'b1, OpC1, 3, 4);
    settle();
    chk("midrst_rdy0", 32'(bus.req0_ready), 32'd1);
    chk("midrst_rdy1", 32'(bus.req1_ready), 32'd0);
    tick();
    chk("midrst_grant", 32'(bus.grant_id), 32'd0);
    chk("midrst_wp", 32'(bus.write_pointer), 32'd0);
    chk("midrst_opa2", bus.operand_a, 32'd1);
    settle();
    chk("midrst_next_rdy1", 32'(bus.req1_ready), 32'd1);
    tick();
    chk("midrst_grant2", 32'(bus.grant_id), 32'd1);
    chk("midrst_count2", 32'(bus.count), 32'd2);
    set_ch0(1'b0, 4'h0, 0, 0);
    set_ch1(1'b0, 4'h0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Exclusive readies, checked continuously on the falling edge.
  always @(negedge clk) begin
    if (!reset && bus.req0_ready && bus.req1_ready) begin
      checks++;
      failures++;
      $error("FAIL ready_exclusive observed=11 expected=not both");
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
